// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared widths and ALU operation encodings for the RV64
//                execute-stage datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NREG       = 1 << REG_ADDR_W;

  // Encodings not listed here (2'b11) select a zero result in the ALU.
  typedef enum logic [1:0] {
    ALUOP_NONE = 2'b00,
    ALUOP_ADD  = 2'b01,
    ALUOP_SLTU = 2'b10
  } aluop_e;

endpackage
`default_nettype wire

// File: rtl/gpr_array.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_array
//  Description : NREG x XLEN general-purpose register file, two asynchronous
//                read ports and one synchronous write port. x0 reads as zero.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clk     in   rising-edge clock
//    rst     in   synchronous active-high reset, clears every register
//    raddr1  in   read port 1 address      rdata1  out  read port 1 data
//    raddr2  in   read port 2 address      rdata2  out  read port 2 data
//    we      in   write enable
//    waddr   in   write address (writes to 0 are dropped)
//    wdata   in   write data
// ============================================================================
module gpr_array
  import core_pkg::*;
#(
  parameter int XLEN = core_pkg::XLEN,
  parameter int NREG = core_pkg::NREG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] raddr1,
  output logic [XLEN-1:0]       rdata1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [XLEN-1:0]       rdata2,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]       wdata
);

  logic [XLEN-1:0] regs_q [NREG];

  // Reset takes priority over a write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  // No write-to-read bypass: a read of the register being written returns
  // the pre-edge contents. x0 is forced to zero at the read mux.
  assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule
`default_nettype wire

// File: rtl/exec_alu_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : exec_alu_regfile
//  Description : Execute-stage datapath for the single-cycle RV64 core:
//                combinational 64-bit ALU (add / sltu) plus the GPR file.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clk, rst            clock, synchronous active-high reset
//    alu_src1, alu_src2  ALU operands (XLEN)
//    aluop               01 = add, 10 = set-less-than-unsigned, else zero
//    alu_result          combinational ALU result (XLEN)
//    raddr1/rdata1       register read port 1
//    raddr2/rdata2       register read port 2
//    we, waddr, wdata    register write port
// ============================================================================
module exec_alu_regfile
  import core_pkg::*;
#(
  parameter int XLEN = core_pkg::XLEN,
  parameter int NREG = core_pkg::NREG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       alu_src1,
  input  logic [XLEN-1:0]       alu_src2,
  input  logic [1:0]            aluop,
  output logic [XLEN-1:0]       alu_result,
  input  logic [REG_ADDR_W-1:0] raddr1,
  output logic [XLEN-1:0]       rdata1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [XLEN-1:0]       rdata2,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]       wdata
);

  // Add wraps modulo 2^XLEN; the compare is unsigned.
  always_comb begin
    alu_result = '0;
    case (aluop)
      ALUOP_ADD:  alu_result = alu_src1 + alu_src2;
      ALUOP_SLTU: alu_result = {{(XLEN-1){1'b0}}, (alu_src1 < alu_src2)};
      default:    alu_result = '0;
    endcase
  end

  gpr_array #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_gpr_array (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .raddr2 (raddr2),
    .rdata2 (rdata2),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_exec_alu_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exec_alu_regfile
//  Description : Self-checking bench for exec_alu_regfile. A behavioural
//                register/ALU model is compared against the DUT every cycle,
//                plus hand-computed literal expectations for directed cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_alu_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] alu_src1, alu_src2, alu_result;
  logic [1:0]  aluop;
  logic [4:0]  raddr1, raddr2, waddr;
  logic [63:0] rdata1, rdata2, wdata;
  logic        we;

  always #5 clk = ~clk;

  exec_alu_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .aluop      (aluop),
    .alu_result (alu_result),
    .raddr1     (raddr1),
    .rdata1     (rdata1),
    .raddr2     (raddr2),
    .rdata2     (rdata2),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata)
  );

  // Reference architectural state: 32 registers, plain array.
  logic [63:0] model [32];
  bit          chk_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] <= 64'd0;
    end else if (we && waddr != 5'd0) begin
      model[waddr] <= wdata;
    end
  end

  function automatic logic [63:0] ref_alu(logic [1:0] op, logic [63:0] a, logic [63:0] b);
    if (op == 2'b01) return a + b;
    if (op == 2'b10) return (a < b) ? 64'd1 : 64'd0;
    return 64'd0;
  endfunction

  function automatic logic [63:0] ref_read(logic [4:0] addr);
    return (addr == 5'd0) ? 64'd0 : model[addr];
  endfunction

  // Literal expectation slots: 0 = alu_result, 1 = rdata1, 2 = rdata2.
  bit          exp_en [3];
  logic [63:0] exp_v  [3];
  string       exp_nm [3];

  int errors = 0;
  int checks = 0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("model_alu",   alu_result, ref_alu(aluop, alu_src1, alu_src2));
      check("model_rdata1", rdata1,    ref_read(raddr1));
      check("model_rdata2", rdata2,    ref_read(raddr2));
      if (exp_en[0]) check(exp_nm[0], alu_result, exp_v[0]);
      if (exp_en[1]) check(exp_nm[1], rdata1,     exp_v[1]);
      if (exp_en[2]) check(exp_nm[2], rdata2,     exp_v[2]);
    end
  end

  task automatic expect_lit(int idx, string nm, logic [63:0] v);
    exp_en[idx] = 1'b1;
    exp_v[idx]  = v;
    exp_nm[idx] = nm;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) exp_en[i] = 1'b0;
  endtask

  // ALU directed table: op, a, b, expected result
  logic [1:0]  t_op  [8] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b11};
  logic [63:0] t_a   [8] = '{64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'd3, 64'd5, 64'd7, 64'd1, 64'hAA, 64'hAA};
  logic [63:0] t_b   [8] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'd1,
                             64'd5, 64'd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'h55, 64'h55};
  logic [63:0] t_r   [8] = '{64'h0000_0000_7FFF_FFFC, 64'd0,
                             64'd1, 64'd0, 64'd0, 64'd1, 64'd0, 64'd0};

  initial begin
    for (int i = 0; i < 3; i++) exp_en[i] = 1'b0;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    raddr1 = '0; raddr2 = '0; aluop = 2'b00; alu_src1 = '0; alu_src2 = '0;
    next_cycle();
    chk_on = 1'b1;

    // 1. All registers zero after reset, on both ports.
    for (int i = 0; i < 32; i++) begin
      rst = 1'b1;
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      expect_lit(1, "reset_rd1", 64'd0);
      expect_lit(2, "reset_rd2", 64'd0);
      next_cycle();
    end
    // Write presented while reset is asserted is ignored.
    rst = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 64'hDEADBEEF_CAFEF00D;
    next_cycle();
    rst = 1'b0; we = 1'b0; raddr1 = 5'd5;
    expect_lit(1, "write_in_reset", 64'd0);
    next_cycle();

    // 2. x0 write dropped; x31 old value during write cycle, new after.
    we = 1'b1; waddr = 5'd0; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    next_cycle();
    waddr = 5'd31; wdata = 64'h1234_5678_8765_4321;
    raddr1 = 5'd0; raddr2 = 5'd31;
    expect_lit(1, "x0_after_write", 64'd0);
    expect_lit(2, "x31_old_in_write_cycle", 64'd0);
    next_cycle();
    we = 1'b0;
    expect_lit(1, "x0_still_zero", 64'd0);
    expect_lit(2, "x31_new", 64'h1234_5678_8765_4321);
    next_cycle();

    // 3-5. ALU directed cases.
    for (int i = 0; i < 8; i++) begin
      aluop = t_op[i]; alu_src1 = t_a[i]; alu_src2 = t_b[i];
      expect_lit(0, $sformatf("alu_case%0d", i), t_r[i]);
      next_cycle();
    end

    // 6. Back-to-back writes to x10, same-address dual read, then reset.
    raddr1 = 5'd10; raddr2 = 5'd10;
    we = 1'b1; waddr = 5'd10; wdata = 64'd1;
    next_cycle();
    wdata = 64'd2;
    expect_lit(1, "x10_first_rd1", 64'd1);
    expect_lit(2, "x10_first_rd2", 64'd1);
    next_cycle();
    we = 1'b0;
    expect_lit(1, "x10_second_rd1", 64'd2);
    expect_lit(2, "x10_second_rd2", 64'd2);
    next_cycle();
    rst = 1'b1; we = 1'b1; wdata = 64'd3;
    next_cycle();
    rst = 1'b0; we = 1'b0;
    expect_lit(1, "x10_after_reset", 64'd0);
    expect_lit(2, "x10_after_reset_p2", 64'd0);
    next_cycle();

    // Randomized traffic checked against the model.
    for (int n = 0; n < 1500; n++) begin
      rst    = ($urandom_range(0, 99) == 0);
      we     = 1'($urandom_range(0, 1));
      waddr  = 5'($urandom_range(0, 31));
      wdata  = {$urandom(), $urandom()};
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
      aluop  = 2'($urandom_range(0, 3));
      alu_src1 = {$urandom(), $urandom()};
      alu_src2 = {$urandom(), $urandom()};
      case ($urandom_range(0, 7))
        0: alu_src2 = alu_src1;
        1: alu_src1 = 64'hFFFF_FFFF_FFFF_FFFF;
        2: alu_src2 = 64'hFFFF_FFFF_FFFF_FFFF;
        3: alu_src1 = 64'(alu_src2 - 64'd1);
        default: ;
      endcase
      next_cycle();
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
